wash_sequencer: RTL and testbench



---
 rtl/wash_sequencer.sv | 256 +++++++++++++++++++++++++
 tb/tb_wash_sequencer.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/wash_sequencer.sv
// Washing-machine program controller: power/begin/set/run/pause/error/finish FSM with phase timer.
// Optional `AUTO_RESUME_EN: leave error on the first tick after the lid closes.
module wash_sequencer #(
    parameter int unsigned IN_SEC     = 2,
    parameter int unsigned WASH_SEC   = 9,
    parameter int unsigned OUT_SEC    = 2,
    parameter int unsigned SPIN_SEC   = 3,
    parameter int unsigned RINSE_SEC  = 6,
    parameter int unsigned FINISH_SEC = 5
) (
    input  logic       cp,
    input  logic       reset,
    input  logic       second,
    input  logic       power_btn,
    input  logic       start_btn,
    input  logic       mode_btn,
    input  logic       lid_open,
    output logic [2:0] state,
    output logic [9:0] data,
    output logic [2:0] shinning,
    output logic [5:0] phase_left,
    output logic [5:0] disp_left,
    output logic [5:0] disp_middle,
    output logic [5:0] disp_right,
    output logic       click
);

    typedef enum logic [2:0] {
        StShutDown = 3'd0,
        StBegin    = 3'd1,
        StSet      = 3'd2,
        StRun      = 3'd3,
        StError    = 3'd4,
        StPause    = 3'd5,
        StFinish   = 3'd6
    } state_e;

    state_e      state_q, state_d;
    logic [2:0]  preset_q, preset_d;
    logic [7:0]  mask_q, mask_d;
    logic [2:0]  shin_q, shin_d;
    logic [5:0]  left_q, left_d;
    logic [5:0]  fin_q, fin_d;
    logic        click_q, click_d;
    logic        second_q;
    logic [9:0]  data_q, data_d;
    logic [5:0]  dl_q, dl_d, dm_q, dm_d, dr_q, dr_d;
    logic        tick;
    logic        accept;
    logic        clear_click;
    logic [7:0]  rem_mask;

    function automatic logic [7:0] preset_mask(input logic [2:0] p);
        case (p)
            3'd0:    preset_mask = 8'hFF;
            3'd1:    preset_mask = 8'hFC;
            3'd2:    preset_mask = 8'h3F;
            3'd3:    preset_mask = 8'h3C;
            3'd4:    preset_mask = 8'h03;
            3'd5:    preset_mask = 8'hC0;
            default: preset_mask = 8'hFF;
        endcase
    endfunction

    // Mask bit 7-p enables phase p; pick the lowest enabled phase index.
    function automatic logic [2:0] first_phase(input logic [7:0] m);
        logic [2:0] idx;
        idx = 3'd0;
        for (int p = 7; p >= 0; p--) begin
            if (m[7-p]) idx = p[2:0];
        end
        return idx;
    endfunction

    function automatic logic [5:0] phase_dur(input logic [2:0] p);
        case (p)
            3'd0, 3'd4: phase_dur = 6'(IN_SEC);
            3'd1:       phase_dur = 6'(WASH_SEC);
            3'd2, 3'd6: phase_dur = 6'(OUT_SEC);
            3'd3, 3'd7: phase_dur = 6'(SPIN_SEC);
            default:    phase_dur = 6'(RINSE_SEC);
        endcase
    endfunction

    function automatic logic [5:0] count_ones(input logic [7:0] m);
        logic [5:0] n;
        n = 6'd0;
        for (int i = 0; i < 8; i++) begin
            n = n + {5'd0, m[i]};
        end
        return n;
    endfunction

    assign tick = second & ~second_q;

    always_ff @(posedge cp) begin
        second_q <= second;
        if (reset) begin
            state_q  <= StShutDown;
            preset_q <= 3'd0;
            mask_q   <= 8'd0;
            shin_q   <= 3'd0;
            left_q   <= 6'd0;
            fin_q    <= 6'd0;
            click_q  <= 1'b0;
            data_q   <= 10'd0;
            dl_q     <= 6'd0;
            dm_q     <= 6'd0;
            dr_q     <= 6'd0;
        end else begin
            state_q  <= state_d;
            preset_q <= preset_d;
            mask_q   <= mask_d;
            shin_q   <= shin_d;
            left_q   <= left_d;
            fin_q    <= fin_d;
            click_q  <= click_d;
            data_q   <= data_d;
            dl_q     <= dl_d;
            dm_q     <= dm_d;
            dr_q     <= dr_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        preset_d    = preset_q;
        mask_d      = mask_q;
        shin_d      = shin_q;
        left_d      = left_q;
        fin_d       = fin_q;
        accept      = 1'b0;
        clear_click = 1'b0;
        rem_mask    = mask_q & ~(8'h80 >> shin_q);

        if (power_btn) begin
            accept = 1'b1;
            if (state_q == StShutDown) begin
                state_d = StBegin;
            end else begin
                state_d     = StShutDown;
                mask_d      = 8'd0;
                shin_d      = 3'd0;
                left_d      = 6'd0;
                fin_d       = 6'd0;
                clear_click = 1'b1;
            end
        end else begin
            case (state_q)
                StBegin, StSet: begin
                    if (mode_btn) begin
                        accept  = 1'b1;
                        state_d = StSet;
                        if (state_q == StSet) begin
                            preset_d = (preset_q == 3'd5) ? 3'd0 : preset_q + 3'd1;
                        end
                    end else if (start_btn && !lid_open) begin
                        accept  = 1'b1;
                        state_d = StRun;
                        mask_d  = preset_mask(preset_q);
                        shin_d  = first_phase(preset_mask(preset_q));
                        left_d  = phase_dur(first_phase(preset_mask(preset_q)));
                    end
                end
                StRun: begin
                    if (lid_open) begin
                        state_d = StError;
                    end else if (start_btn) begin
                        accept  = 1'b1;
                        state_d = StPause;
                    end else if (tick) begin
                        if (left_q > 6'd1) begin
                            left_d = left_q - 6'd1;
                        end else begin
                            mask_d = rem_mask;
                            if (rem_mask == 8'd0) begin
                                state_d = StFinish;
                                left_d  = 6'd0;
                                fin_d   = 6'(FINISH_SEC);
                            end else begin
                                shin_d = first_phase(rem_mask);
                                left_d = phase_dur(first_phase(rem_mask));
                            end
                        end
                    end
                end
                StPause: begin
                    if (lid_open) begin
                        state_d = StError;
                    end else if (start_btn) begin
                        accept  = 1'b1;
                        state_d = StRun;
                    end
                end
                StError: begin
                    if (start_btn && !lid_open) begin
                        accept  = 1'b1;
                        state_d = StRun;
                    end
`ifdef AUTO_RESUME_EN
                    else if (tick && !lid_open) begin
                        state_d = StRun;
                    end
`endif
                end
                StFinish: begin
                    if (tick) begin
                        if (fin_q <= 6'd1) begin
                            state_d = StShutDown;
                            fin_d   = 6'd0;
                            shin_d  = 3'd0;
                            mask_d  = 8'd0;
                        end else begin
                            fin_d = fin_q - 6'd1;
                        end
                    end
                end
                default: state_d = state_q;
            endcase
        end

        // A press on a tick cycle wins over the tick clear.
        click_d = tick ? 1'b0 : click_q;
        if (accept) click_d = 1'b1;
        if (clear_click) click_d = 1'b0;
    end

    always_comb begin
        data_d = {state_d == StSet, state_d != StShutDown, mask_d};
        dl_d   = 6'd0;
        dm_d   = 6'd0;
        dr_d   = 6'd0;
        case (state_d)
            StRun, StPause, StError: begin
                dl_d = {3'd0, shin_d};
                dm_d = left_d / 6'd10;
                dr_d = left_d % 6'd10;
            end
            StSet: begin
                dl_d = {3'd0, preset_d};
                dm_d = count_ones(preset_mask(preset_d));
            end
            default: ;
        endcase
    end

    assign state       = state_q;
    assign data        = data_q;
    assign shinning    = shin_q;
    assign phase_left  = left_q;
    assign disp_left   = dl_q;
    assign disp_middle = dm_q;
    assign disp_right  = dr_q;
    assign click       = click_q;

endmodule

// File: tb/tb_wash_sequencer.sv
// Directed self-checking bench for wash_sequencer; honours `AUTO_RESUME_EN for error-exit checks.
module tb_wash_sequencer;

    logic       cp = 1'b0;
    logic       reset = 1'b1;
    logic       second = 1'b0;
    logic       power_btn = 1'b0;
    logic       start_btn = 1'b0;
    logic       mode_btn = 1'b0;
    logic       lid_open = 1'b0;
    logic [2:0] state;
    logic [9:0] data;
    logic [2:0] shinning;
    logic [5:0] phase_left;
    logic [5:0] disp_left;
    logic [5:0] disp_middle;
    logic [5:0] disp_right;
    logic       click;

    int checks = 0;
    int failures = 0;

    wash_sequencer dut (
        .cp          (cp),
        .reset       (reset),
        .second      (second),
        .power_btn   (power_btn),
        .start_btn   (start_btn),
        .mode_btn    (mode_btn),
        .lid_open    (lid_open),
        .state       (state),
        .data        (data),
        .shinning    (shinning),
        .phase_left  (phase_left),
        .disp_left   (disp_left),
        .disp_middle (disp_middle),
        .disp_right  (disp_right),
        .click       (click)
    );

    initial forever #5 cp = ~cp;

    task automatic cyc();
        @(posedge cp);
        #1;
    endtask

    task automatic press_power();
        power_btn = 1'b1; cyc(); power_btn = 1'b0;
    endtask

    task automatic press_start();
        start_btn = 1'b1; cyc(); start_btn = 1'b0;
    endtask

    task automatic press_mode();
        mode_btn = 1'b1; cyc(); mode_btn = 1'b0;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            second = 1'b1; cyc(); second = 1'b0; cyc();
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; cyc(); cyc(); reset = 1'b0; cyc();
        checks++; if (state !== 3'd0) begin failures++;
            $display("FAIL reset_state got=%0d want=0", state); end
        checks++; if (data !== 10'd0) begin failures++;
            $display("FAIL reset_data got=%h want=000", data); end
        checks++; if ({shinning, phase_left} !== 9'd0) begin failures++;
            $display("FAIL reset_phase got=%0d/%0d want=0/0", shinning, phase_left); end
        checks++; if ({disp_left, disp_middle, disp_right, click} !== 19'd0) begin failures++;
            $display("FAIL reset_disp got=%0d%0d%0d click=%0d want=0000", disp_left,
                     disp_middle, disp_right, click); end
    endtask

    task automatic test_full_program();
        press_power();
        checks++; if (state !== 3'd1 || data !== 10'h100 || click !== 1'b1) begin failures++;
            $display("FAIL power_on got=%0d/%h/%0d want=1/100/1", state, data, click); end
        press_start();
        checks++; if (state !== 3'd3 || shinning !== 3'd0 || phase_left !== 6'd2
                      || data !== 10'h1FF) begin failures++;
            $display("FAIL run_start got=%0d/%0d/%0d/%h want=3/0/2/1ff", state, shinning,
                     phase_left, data); end
        ticks(2);
        checks++; if (shinning !== 3'd1 || phase_left !== 6'd9 || data !== 10'h17F
                      || click !== 1'b0) begin failures++;
            $display("FAIL phase1 got=%0d/%0d/%h/%0d want=1/9/17f/0", shinning, phase_left,
                     data, click); end
        checks++; if (disp_left !== 6'd1 || disp_middle !== 6'd0 || disp_right !== 6'd9)
            begin failures++;
            $display("FAIL run_disp got=%0d%0d%0d want=109", disp_left, disp_middle,
                     disp_right); end
        ticks(26);
        checks++; if (state !== 3'd3 || shinning !== 3'd7 || phase_left !== 6'd1
                      || data !== 10'h101) begin failures++;
            $display("FAIL last_sec got=%0d/%0d/%0d/%h want=3/7/1/101", state, shinning,
                     phase_left, data); end
        ticks(1);
        checks++; if (state !== 3'd6 || data !== 10'h100) begin failures++;
            $display("FAIL finish got=%0d/%h want=6/100", state, data); end
        ticks(4);
        checks++; if (state !== 3'd6) begin failures++;
            $display("FAIL finish_hold got=%0d want=6", state); end
        ticks(1);
        checks++; if (state !== 3'd0 || data !== 10'h000) begin failures++;
            $display("FAIL auto_off got=%0d/%h want=0/000", state, data); end
    endtask

    task automatic test_preset_select();
        press_power();
        for (int i = 0; i < 5; i++) press_mode();
        checks++; if (state !== 3'd2 || data !== 10'h300 || disp_left !== 6'd4
                      || disp_middle !== 6'd2 || disp_right !== 6'd0) begin failures++;
            $display("FAIL set_p4 got=%0d/%h/%0d%0d%0d want=2/300/420", state, data,
                     disp_left, disp_middle, disp_right); end
        press_start();
        checks++; if (state !== 3'd3 || shinning !== 3'd6 || phase_left !== 6'd2
                      || data !== 10'h103) begin failures++;
            $display("FAIL dry_start got=%0d/%0d/%0d/%h want=3/6/2/103", state, shinning,
                     phase_left, data); end
        ticks(5);
        checks++; if (state !== 3'd6) begin failures++;
            $display("FAIL dry_finish got=%0d want=6", state); end
        press_power();
        checks++; if (state !== 3'd0) begin failures++;
            $display("FAIL finish_power got=%0d want=0", state); end
        press_power();
        press_mode();
        checks++; if (state !== 3'd2 || disp_left !== 6'd4) begin failures++;
            $display("FAIL preset_kept got=%0d/%0d want=2/4", state, disp_left); end
        press_mode();
        press_mode();
        checks++; if (disp_left !== 6'd0 || disp_middle !== 6'd8) begin failures++;
            $display("FAIL preset_wrap got=%0d/%0d want=0/8", disp_left, disp_middle); end
        press_power();
    endtask

    task automatic test_pause();
        reset = 1'b1; cyc(); reset = 1'b0; cyc();
        press_power();
        press_start();
        ticks(6);
        checks++; if (shinning !== 3'd1 || phase_left !== 6'd5) begin failures++;
            $display("FAIL pre_pause got=%0d/%0d want=1/5", shinning, phase_left); end
        press_start();
        checks++; if (state !== 3'd5) begin failures++;
            $display("FAIL pause got=%0d want=5", state); end
        ticks(3);
        checks++; if (state !== 3'd5 || phase_left !== 6'd5) begin failures++;
            $display("FAIL pause_hold got=%0d/%0d want=5/5", state, phase_left); end
        press_start();
        checks++; if (state !== 3'd3 || phase_left !== 6'd5 || shinning !== 3'd1)
            begin failures++;
            $display("FAIL resume got=%0d/%0d/%0d want=3/5/1", state, phase_left, shinning); end
        ticks(1);
        checks++; if (phase_left !== 6'd4) begin failures++;
            $display("FAIL resume_tick got=%0d want=4", phase_left); end
        start_btn = 1'b1; second = 1'b1; cyc(); start_btn = 1'b0; second = 1'b0; cyc();
        checks++; if (state !== 3'd5 || phase_left !== 6'd4 || click !== 1'b1)
            begin failures++;
            $display("FAIL pause_on_tick got=%0d/%0d/%0d want=5/4/1", state, phase_left,
                     click); end
        press_start();
    endtask

    task automatic test_lid_error();
        ticks(1);
        lid_open = 1'b1; second = 1'b1; cyc(); second = 1'b0; cyc();
        checks++; if (state !== 3'd4 || phase_left !== 6'd3 || disp_right !== 6'd3)
            begin failures++;
            $display("FAIL lid_error got=%0d/%0d/%0d want=4/3/3", state, phase_left,
                     disp_right); end
        lid_open = 1'b0;
        ticks(1);
`ifdef AUTO_RESUME_EN
        checks++; if (state !== 3'd3 || phase_left !== 6'd3) begin failures++;
            $display("FAIL auto_resume got=%0d/%0d want=3/3", state, phase_left); end
`else
        checks++; if (state !== 3'd4 || phase_left !== 6'd3) begin failures++;
            $display("FAIL error_hold got=%0d/%0d want=4/3", state, phase_left); end
        press_start();
        checks++; if (state !== 3'd3 || phase_left !== 6'd3) begin failures++;
            $display("FAIL error_resume got=%0d/%0d want=3/3", state, phase_left); end
`endif
        ticks(1);
        checks++; if (phase_left !== 6'd2) begin failures++;
            $display("FAIL post_error_tick got=%0d want=2", phase_left); end
    endtask

    task automatic test_power_mid_run();
        press_power();
        checks++; if (state !== 3'd0 || data !== 10'd0 || shinning !== 3'd0
                      || phase_left !== 6'd0 || click !== 1'b0) begin failures++;
            $display("FAIL power_off got=%0d/%h/%0d/%0d/%0d want=0/000/0/0/0", state, data,
                     shinning, phase_left, click); end
        press_power();
        press_mode();
        press_mode();
        press_start();
        checks++; if (state !== 3'd3 || data !== 10'h1FC || phase_left !== 6'd2)
            begin failures++;
            $display("FAIL p1_start got=%0d/%h/%0d want=3/1fc/2", state, data, phase_left); end
        ticks(1);
        press_power();
        press_power();
        press_mode();
        checks++; if (disp_left !== 6'd1 || disp_middle !== 6'd6) begin failures++;
            $display("FAIL preset_after_off got=%0d/%0d want=1/6", disp_left, disp_middle); end
        press_start();
        ticks(1);
        second = 1'b1;
        reset = 1'b1; cyc(); reset = 1'b0;
        checks++; if (state !== 3'd0 || data !== 10'd0 || phase_left !== 6'd0
                      || disp_left !== 6'd0 || click !== 1'b0) begin failures++;
            $display("FAIL reset_mid_run got=%0d/%h/%0d/%0d/%0d want=0/000/0/0/0", state,
                     data, phase_left, disp_left, click); end
        cyc(); second = 1'b0; cyc();
        press_power();
        press_mode();
        checks++; if (disp_left !== 6'd0 || state !== 3'd2) begin failures++;
            $display("FAIL preset_reset got=%0d/%0d want=0/2", disp_left, state); end
        press_power();
    endtask

    task automatic test_lid_begin();
        press_power();
        ticks(1);
        lid_open = 1'b1;
        press_start();
        checks++; if (state !== 3'd1 || click !== 1'b0) begin failures++;
            $display("FAIL lid_start got=%0d/%0d want=1/0", state, click); end
        lid_open = 1'b0;
        press_start();
        checks++; if (state !== 3'd3 || click !== 1'b1) begin failures++;
            $display("FAIL closed_start got=%0d/%0d want=3/1", state, click); end
        cyc();
        checks++; if (click !== 1'b1) begin failures++;
            $display("FAIL click_hold got=%0d want=1", click); end
        ticks(1);
        checks++; if (click !== 1'b0) begin failures++;
            $display("FAIL click_clear got=%0d want=0", click); end
        press_power();
    endtask

    initial begin
        test_reset();
        test_full_program();
        test_preset_select();
        test_pause();
        test_lid_error();
        test_power_mid_run();
        test_lid_begin();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
